// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with parity, framing and busy reporting
// Define UART_RX_BREAK_DETECT_EN to add break detection on o_Break.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 ||
        DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_rx_cfg: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ferr_now;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;

`ifdef UART_RX_BREAK_DETECT_EN
  logic                 zero_q, zero_d;
  logic                 zero_now;
  logic                 brk_q, brk_d;
`endif

  always_comb begin
    rx_meta_d  = i_Rx_Serial;
    rx_s_d     = rx_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ferr_now   = ferr_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
`ifdef UART_RX_BREAK_DETECT_EN
    zero_d     = zero_q;
    zero_now   = zero_q;
    brk_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        par_d  = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_d = 1'b1;
`endif
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      // Mid-start-bit recheck rejects glitches shorter than half a bit.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IW'(i)) begin
              shift_d[i] = rx_s_q;
            end
          end
          par_d = par_q ^ rx_s_q;
`ifdef UART_RX_BREAK_DETECT_EN
          zero_d = zero_q & ~rx_s_q;
`endif
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = ((par_q ^ rx_s_q) != (PARITY_MODE == 1));
`ifdef UART_RX_BREAK_DETECT_EN
          zero_d  = zero_q & ~rx_s_q;
`endif
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          ferr_now = ferr_q | ~rx_s_q;
          ferr_d   = ferr_now;
`ifdef UART_RX_BREAK_DETECT_EN
          zero_now = (idx_q == '0) ? (zero_q & ~rx_s_q) : zero_q;
          zero_d   = zero_now;
`endif
          if (idx_q == IDX_STOP_LAST) begin
            idx_d      = '0;
            dv_d       = 1'b1;
            byte_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_now;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_d      = zero_now;
`endif
            // A line still low after the last stop must go high before a new start.
            state_d    = rx_s_q ? IDLE : WAIT_HIGH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      zero_q <= 1'b1;
      brk_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      brk_q  <= brk_d;
    end
  end

  assign o_Break = brk_q;
`else
  assign o_Break = 1'b0;
`endif

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  // Busy covers the DV cycle so it drops the cycle after the frame is delivered.
  assign o_Busy       = (state_q != IDLE) | dv_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - frame-level model bench for uart_rx_cfg (8N1, 8E1, 5N2 instances)
module tb_uart_rx_cfg;

  localparam int C = 8;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef struct packed {
    int         dut;
    int         cyc;
    logic [8:0] byte_v;
    logic       pe;
    logic       fe;
    logic       br;
    logic       busy_fall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       line_a, line_b, line_c;
  logic       dv_a, pe_a, fe_a, br_a, busy_a;
  logic       dv_b, pe_b, fe_b, br_b, busy_b;
  logic       dv_c, pe_c, fe_c, br_c, busy_c;
  logic [7:0] byte_a, byte_b;
  logic [4:0] byte_c;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(line_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Break(br_a), .o_Busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(line_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Break(br_b), .o_Busy(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(line_c), .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c),
    .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Break(br_c), .o_Busy(busy_c));

  int cfg_d[3]    = '{8, 8, 5};
  int cfg_p[3]    = '{0, 1, 0};
  int cfg_mode[3] = '{0, 2, 0};
  int cfg_s[3]    = '{1, 1, 2};

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  bit   rst_seen = 1'b0;
  exp_t exp_q[$];

  logic [8:0] h_byte[3];
  logic       h_pe[3];
  logic       h_fe[3];
  bit         bf_pend[3];
  int         last_dv[3];
  logic       last_br[3];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= !rst_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       line_a = v;
      1:       line_b = v;
      default: line_c = v;
    endcase
  endtask

  // Builds the frame, predicts the result from the frame contents, then drives it.
  task automatic send(input int d, input logic [8:0] data, input logic pbit,
                      input logic [1:0] stops, input int tail_bits, input bit busy_fall);
    int         nd, np, ns, nb, ones;
    logic [15:0] bits;
    logic       zero;
    exp_t       e;
    nd   = cfg_d[d];
    np   = cfg_p[d];
    ns   = cfg_s[d];
    nb   = 1 + nd + np + ns;
    bits = '0;
    for (int i = 0; i < nd; i++) bits[1+i] = data[i];
    if (np != 0) bits[1+nd] = pbit;
    for (int i = 0; i < ns; i++) bits[1+nd+np+i] = stops[i];

    e        = '0;
    e.dut    = d;
    ones     = 0;
    for (int i = 0; i < nd; i++) begin
      e.byte_v[i] = bits[1+i];
      ones += int'(bits[1+i]);
    end
    e.pe = (np != 0) && (((ones + int'(bits[1+nd])) % 2) != ((cfg_mode[d] == 1) ? 1 : 0));
    e.fe = 1'b0;
    for (int i = 0; i < ns; i++) if (!bits[1+nd+np+i]) e.fe = 1'b1;
    zero = 1'b1;
    for (int i = 1; i <= nd + np + 1; i++) if (bits[i]) zero = 1'b0;
    e.br        = BRK_EN && zero;
    e.busy_fall = busy_fall;
    e.cyc       = cyc + 1 + 3 + (C - 1) / 2 + (nd + np + ns) * C;
    exp_q.push_back(e);

    for (int i = 0; i < nb; i++) begin
      set_line(d, bits[i]);
      repeat (C) tick();
    end
    if (tail_bits > 0) begin
      set_line(d, 1'b0);
      repeat (tail_bits * C) tick();
    end
    set_line(d, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk_eq("pending_dv", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  task automatic cmp(input int d, input logic dv, input logic [8:0] b, input logic pe,
                     input logic fe, input logic br, input logic busy);
    exp_t e;
    if (bf_pend[d]) begin
      bf_pend[d] = 1'b0;
      chk_eq($sformatf("busy_fall[%0d]", d), busy, 0);
    end
    if (dv === 1'b1) begin
      chk_eq($sformatf("dv_expected[%0d]", d), (exp_q.size() > 0 && exp_q[0].dut == d), 1);
      if (exp_q.size() > 0 && exp_q[0].dut == d) begin
        e = exp_q.pop_front();
        chk_rng($sformatf("dv_cycle[%0d]", d), cyc, e.cyc - 1, e.cyc + 1);
        chk_eq($sformatf("byte[%0d]", d), b, e.byte_v);
        chk_eq($sformatf("parity_err[%0d]", d), pe, e.pe);
        chk_eq($sformatf("frame_err[%0d]", d), fe, e.fe);
        chk_eq($sformatf("break[%0d]", d), br, e.br);
        chk_eq($sformatf("busy_at_dv[%0d]", d), busy, 1);
        h_byte[d]  = e.byte_v;
        h_pe[d]    = e.pe;
        h_fe[d]    = e.fe;
        bf_pend[d] = e.busy_fall;
        last_dv[d] = cyc;
        last_br[d] = br;
      end
    end else begin
      chk_eq($sformatf("dv_idle[%0d]", d), dv, 0);
      chk_eq($sformatf("byte_hold[%0d]", d), b, h_byte[d]);
      chk_eq($sformatf("parity_hold[%0d]", d), pe, h_pe[d]);
      chk_eq($sformatf("frame_hold[%0d]", d), fe, h_fe[d]);
      chk_eq($sformatf("break_idle[%0d]", d), br, 0);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (rst_seen) begin
        for (int i = 0; i < 3; i++) begin
          h_byte[i]  = '0;
          h_pe[i]    = 1'b0;
          h_fe[i]    = 1'b0;
          bf_pend[i] = 1'b0;
        end
      end
      cmp(0, dv_a, {1'b0, byte_a}, pe_a, fe_a, br_a, busy_a);
      cmp(1, dv_b, {1'b0, byte_b}, pe_b, fe_b, br_b, busy_b);
      cmp(2, dv_c, {4'b0, byte_c}, pe_c, fe_c, br_c, busy_c);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int i = 0; i < 3; i++) begin
      h_byte[i]  = '0;
      h_pe[i]    = 1'b0;
      h_fe[i]    = 1'b0;
      bf_pend[i] = 1'b0;
      last_dv[i] = 0;
      last_br[i] = 1'b0;
    end
    rst_n  = 1'b0;
    line_a = 1'b1;
    line_b = 1'b1;
    line_c = 1'b1;
    repeat (4) tick();
    rst_n = 1'b1;
    tick();

    chk_eq("rst_dv_a", dv_a, 0);
    chk_eq("rst_byte_a", byte_a, 0);
    chk_eq("rst_busy_a", busy_a, 0);
    chk_eq("rst_ferr_a", fe_a, 0);
    chk_eq("rst_perr_b", pe_b, 0);
    chk_eq("rst_byte_c", byte_c, 0);
    armed = 1'b1;

    // 8N1 0xA5: nominal latency 3 + 3 + 9*8 = 78 edges after the first low sample
    t0 = cyc;
    send(0, 9'h0A5, 1'b0, 2'b11, 0, 1'b1);
    drain();
    chk_rng("t1_latency", last_dv[0] - t0, 78, 80);
    chk_eq("t1_byte", byte_a, 8'hA5);
    chk_eq("t1_perr", pe_a, 0);
    chk_eq("t1_ferr", fe_a, 0);

    // Even parity 0x37 (five ones): parity bit 1 is correct, 0 is wrong
    t0 = cyc;
    send(1, 9'h037, 1'b1, 2'b11, 0, 1'b1);
    drain();
    chk_rng("t2_latency", last_dv[1] - t0, 86, 88);
    chk_eq("t2_perr_good", pe_b, 0);
    send(1, 9'h037, 1'b0, 2'b11, 0, 1'b1);
    drain();
    chk_eq("t2_perr_bad", pe_b, 1);
    chk_eq("t2_byte", byte_b, 8'h37);

    // 5N2 0x15, second stop low, line held low for 3 more bit times
    t0 = cyc;
    send(2, 9'h015, 1'b0, 2'b01, 3, 1'b0);
    @(negedge clk);
    chk_eq("t3_busy_low_line", busy_c, 1);
    repeat (6) tick();
    chk_eq("t3_busy_released", busy_c, 0);
    drain();
    chk_rng("t3_latency", last_dv[2] - t0, 62, 64);
    chk_eq("t3_byte", byte_c, 5'h15);
    chk_eq("t3_ferr", fe_c, 1);
    send(2, 9'h00A, 1'b0, 2'b11, 0, 1'b1);
    drain();
    chk_eq("t3_next_byte", byte_c, 5'h0A);
    chk_eq("t3_next_ferr", fe_c, 0);

    // Back-to-back frames, then a single-stop framing error
    send(0, 9'h000, 1'b0, 2'b11, 0, 1'b1);
    send(0, 9'h0FF, 1'b0, 2'b11, 0, 1'b1);
    drain();
    send(0, 9'h081, 1'b0, 2'b00, 0, 1'b0);
    drain();
    chk_eq("ferr_byte", byte_a, 8'h81);
    chk_eq("ferr_flag", fe_a, 1);

    // 3-cycle glitch on an idle line
    line_a = 1'b0;
    repeat (3) tick();
    line_a = 1'b1;
    repeat (20) tick();
    chk_eq("t4_busy", busy_a, 0);
    chk_eq("t4_byte_kept", byte_a, 8'h81);
    chk_eq("t4_ferr_kept", fe_a, 1);

    // Reset pulse during data bit 4 of an 0xFF frame
    line_a = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 4; i++) begin
      line_a = 1'b1;
      repeat (C) tick();
    end
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5 * C) tick();
    chk_eq("t5_dv", dv_a, 0);
    chk_eq("t5_byte", byte_a, 0);
    chk_eq("t5_ferr", fe_a, 0);
    chk_eq("t5_busy", busy_a, 0);
    chk_eq("t5_byte_b", byte_b, 0);
    send(0, 9'h03C, 1'b0, 2'b11, 0, 1'b1);
    drain();
    chk_eq("t5_next_byte", byte_a, 8'h3C);

    // Line held low for 20 bit times
    send(0, 9'h000, 1'b0, 2'b00, 10, 1'b0);
    repeat (6) tick();
    chk_eq("t6_busy", busy_a, 0);
    drain();
    chk_eq("t6_byte", byte_a, 8'h00);
    chk_eq("t6_ferr", fe_a, 1);
    chk_eq("t6_break", last_br[0], BRK_EN);

    repeat (10) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
